gpio_seq_ctrl: RTL and testbench
================================

GPIO_SEQ_CTRL -- requirements
Module: gpio_seq_ctrl

Interface
REQ-001 The block SHALL have parameter GPIO_NUM, default 32, giving the pattern width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, giving the number of pattern entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, giving the hold-counter width.
REQ-004 Port pclk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port prst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port push_valid_i, input, 1 bit: entry offered.
REQ-007 Port push_ready_o, output, 1 bit: entry accepted when both push_valid_i and push_ready_o are high.
REQ-008 Port push_data_i, input, GPIO_NUM bits: pattern value.
REQ-009 Port push_mask_i, input, GPIO_NUM bits: bits of the pattern to update.
REQ-010 Port push_hold_i, input, CNT_WIDTH bits: cycles the entry is held.
REQ-011 Port start_i, input, 1 bit: start playback.
REQ-012 Port stop_i, input, 1 bit: abort playback.
REQ-013 Port flush_i, input, 1 bit: empty the FIFO and go idle.
REQ-014 Port gpio_out_o, output, GPIO_NUM bits: pattern driven to the gpio_out path.
REQ-015 Port busy_o, output, 1 bit: high while in state RUN.
REQ-016 Port done_o, output, 1 bit: one-cycle pulse at normal completion.
REQ-017 Port fifo_cnt_o, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-018 Port irq_o, output, 1 bit: sticky completion interrupt.
REQ-019 Port irq_clr_i, input, 1 bit: clears irq_o.

Function
REQ-020 push_ready_o SHALL equal not-full, and a push SHALL be accepted only when the FIFO is not full, including in the same cycle as a pop.
REQ-021 An accepted entry SHALL become visible to the FSM on the cycle after it is accepted.
REQ-022 The FSM SHALL have exactly two states, IDLE and RUN.
REQ-023 In IDLE, start_i high with the FIFO non-empty SHALL, at that edge, pop the head entry, update gpio_out_o, load the counter and enter RUN.
REQ-024 A pop SHALL update the output as gpio_out_o <= (gpio_out_o & ~mask) | (data & mask).
REQ-025 On a pop the counter SHALL load max(hold, 1), so hold 0 behaves as 1.
REQ-026 Each entry SHALL remain on gpio_out_o for exactly max(hold, 1) cycles.
REQ-027 In IDLE, start_i with the FIFO empty SHALL be ignored; start_i in RUN SHALL be ignored.
REQ-028 In RUN with counter > 1, the counter SHALL decrement by 1 each cycle.
REQ-029 In RUN with counter == 1 and the FIFO non-empty, the block SHALL pop the next entry and apply it at that edge, with no gap cycle.
REQ-030 In RUN with counter == 1 and the FIFO empty, the block SHALL go to IDLE and pulse done_o for 1 cycle; gpio_out_o SHALL hold its last value.
REQ-031 stop_i in RUN SHALL cause IDLE at that edge, with no done_o pulse, with gpio_out_o retained and with the remaining FIFO entries retained.
REQ-032 flush_i SHALL empty the FIFO and force IDLE at that edge, with no done_o pulse and with gpio_out_o retained.
REQ-033 flush_i SHALL block any push in the same cycle.
REQ-034 Priority among simultaneous inputs SHALL be flush_i > stop_i > start_i.
REQ-035 A push arriving in the same cycle as counter == 1 with the FIFO empty SHALL NOT extend the sequence.

Reset
REQ-036 With prst high at a clock edge: state SHALL be IDLE, the FIFO empty, fifo_cnt_o = 0, gpio_out_o = 0, counter = 0, busy_o = 0, done_o = 0, irq_o = 0, push_ready_o = 1.
REQ-037 Reset asserted mid-RUN SHALL abort playback and discard all entries.

Configuration
REQ-038 The macro GPIO_SEQ_IRQ_EN SHALL select the completion-interrupt feature.
REQ-039 With GPIO_SEQ_IRQ_EN defined, irq_o SHALL set on each done_o pulse and stay set until irq_clr_i is high.
REQ-040 With GPIO_SEQ_IRQ_EN defined, if a set and irq_clr_i occur in the same cycle, the set SHALL win.
REQ-041 Without GPIO_SEQ_IRQ_EN, irq_o SHALL be tied to 0, irq_clr_i SHALL be ignored, and no irq flop SHALL be built.

Structure
REQ-042 Package gpio_seq_pkg SHALL hold the state enum (IDLE, RUN) and a packed entry struct {data, mask, hold}.
REQ-043 Package gpio_seq_pkg SHALL hold the default parameter constants.
REQ-044 The FIFO SHALL be a sub-module, gpio_seq_fifo: synchronous, with wrap-around read/write pointers, full/empty flags and count, and with data not reset.

Verification
REQ-045 Reset, push 3 entries (data 0x1/0x2/0x4, mask 0xF, hold 2/0/3), start_i -> gpio_out_o = 0x1 for 2 cycles, then 0x2 for 1 cycle, then 0x4 for 3 cycles; done_o pulses once; busy_o high 6 cycles.
REQ-046 gpio_out_o = 0xFF00, push data 0x00FF with mask 0x0F0F, start -> gpio_out_o = 0xF00F.
REQ-047 Push FIFO_DEPTH entries, then one more -> push_ready_o = 0 and the extra entry is dropped; fifo_cnt_o = 8.
REQ-048 4 entries with hold 5, stop_i on cycle 3 of the first entry -> IDLE next edge, no done_o, fifo_cnt_o = 3; a new start resumes with entry 2.
REQ-049 flush_i, stop_i and start_i asserted together in RUN -> IDLE, fifo_cnt_o = 0, no done_o.
REQ-050 With GPIO_SEQ_IRQ_EN defined: completion -> irq_o = 1 and held; irq_clr_i -> 0; set and clear in the same cycle -> irq_o = 1.

Source files
------------

// File: rtl/gpio_seq_pkg.sv
// Shared types and default sizing for the GPIO pattern sequencer.
package gpio_seq_pkg;

  localparam int GPIO_NUM_DEF   = 32;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Entry layout at the default widths; the top rebuilds the same field order at its own widths.
  typedef struct packed {
    logic [GPIO_NUM_DEF-1:0]  data;
    logic [GPIO_NUM_DEF-1:0]  mask;
    logic [CNT_WIDTH_DEF-1:0] hold;
  } entry_t;

endpackage

// File: rtl/gpio_seq_fifo.sv
// Synchronous FIFO with wrap-around pointers and occupancy count; storage is not reset.
module gpio_seq_fifo
  import gpio_seq_pkg::*;
#(
  parameter int WIDTH = 2 * GPIO_NUM_DEF + CNT_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = mem[rd_ptr];

  // Full blocks a write even when a read frees a slot in the same cycle.
  assign wr_ok = wr_en && !full && !flush;
  assign rd_ok = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gpio_seq_ctrl.sv
// GPIO pattern sequencer: plays masked FIFO entries onto gpio_out_o, each for max(hold,1) cycles.
// Define GPIO_SEQ_IRQ_EN to build the sticky completion interrupt irq_o.
module gpio_seq_ctrl
  import gpio_seq_pkg::*;
#(
  parameter int GPIO_NUM   = GPIO_NUM_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                          pclk,
  input  logic                          prst,
  input  logic                          push_valid_i,
  output logic                          push_ready_o,
  input  logic [GPIO_NUM-1:0]           push_data_i,
  input  logic [GPIO_NUM-1:0]           push_mask_i,
  input  logic [CNT_WIDTH-1:0]          push_hold_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic                          flush_i,
  output logic [GPIO_NUM-1:0]           gpio_out_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          irq_o,
  input  logic                          irq_clr_i
);

  localparam int EW = 2 * GPIO_NUM + CNT_WIDTH;

  typedef struct packed {
    logic [GPIO_NUM-1:0]  data;
    logic [GPIO_NUM-1:0]  mask;
    logic [CNT_WIDTH-1:0] hold;
  } slot_t;

  function automatic logic [CNT_WIDTH-1:0] hold_load(input logic [CNT_WIDTH-1:0] h);
    return (h == '0) ? CNT_WIDTH'(1) : h;
  endfunction

  function automatic logic [GPIO_NUM-1:0] apply_mask(input logic [GPIO_NUM-1:0] cur,
                                                     input logic [GPIO_NUM-1:0] d,
                                                     input logic [GPIO_NUM-1:0] m);
    return (cur & ~m) | (d & m);
  endfunction

  state_e               state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [GPIO_NUM-1:0]  gpio_q, gpio_n;
  logic                 done_q, done_n;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [EW-1:0]        fifo_rd_data;
  slot_t                head;

  gpio_seq_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pclk),
    .rst     (prst),
    .flush   (flush_i),
    .wr_en   (push_valid_i),
    .wr_data ({push_data_i, push_mask_i, push_hold_i}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt_o)
  );

  assign head         = slot_t'(fifo_rd_data);
  assign push_ready_o = !fifo_full;
  assign busy_o       = (state == RUN);
  assign gpio_out_o   = gpio_q;
  assign done_o       = done_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    gpio_n  = gpio_q;
    pop     = 1'b0;
    done_n  = 1'b0;
    if (flush_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !fifo_empty) begin
            pop     = 1'b1;
            state_n = RUN;
          end
        end
        RUN: begin
          if (stop_i) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else if (cnt > CNT_WIDTH'(1)) begin
            cnt_n = cnt - CNT_WIDTH'(1);
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    // A pop applies the head entry at the same edge, so back-to-back entries leave no gap.
    if (pop) begin
      gpio_n = apply_mask(gpio_q, head.data, head.mask);
      cnt_n  = hold_load(head.hold);
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state  <= IDLE;
      cnt    <= '0;
      gpio_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      gpio_q <= gpio_n;
      done_q <= done_n;
    end
  end

`ifdef GPIO_SEQ_IRQ_EN
  logic irq_q;

  // Set takes precedence over a clear arriving in the same cycle.
  always_ff @(posedge pclk) begin
    if (prst) begin
      irq_q <= 1'b0;
    end else if (done_n) begin
      irq_q <= 1'b1;
    end else if (irq_clr_i) begin
      irq_q <= 1'b0;
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_clr;

  assign unused_irq_clr = irq_clr_i;
  assign irq_o          = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Directed scoreboard bench for gpio_seq_ctrl at default parameters.
module tb_gpio_seq_ctrl;
  import gpio_seq_pkg::*;

`ifdef GPIO_SEQ_IRQ_EN
  localparam logic [31:0] IRQ_EXP = 32'd1;
`else
  localparam logic [31:0] IRQ_EXP = 32'd0;
`endif

  logic        pclk = 1'b0;
  logic        prst;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] push_data_i;
  logic [31:0] push_mask_i;
  logic [15:0] push_hold_i;
  logic        start_i;
  logic        stop_i;
  logic        flush_i;
  logic [31:0] gpio_out_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  fifo_cnt_o;
  logic        irq_o;
  logic        irq_clr_i;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_gpio = '0;
  logic [31:0] exp_q [$];

  always #5 pclk = ~pclk;

  gpio_seq_ctrl dut (
    .pclk         (pclk),
    .prst         (prst),
    .push_valid_i (push_valid_i),
    .push_ready_o (push_ready_o),
    .push_data_i  (push_data_i),
    .push_mask_i  (push_mask_i),
    .push_hold_i  (push_hold_i),
    .start_i      (start_i),
    .stop_i       (stop_i),
    .flush_i      (flush_i),
    .gpio_out_o   (gpio_out_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .fifo_cnt_o   (fifo_cnt_o),
    .irq_o        (irq_o),
    .irq_clr_i    (irq_clr_i)
  );

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one entry for a cycle; accepted entries extend the expected per-cycle output stream.
  task automatic push(input logic [31:0] d, input logic [31:0] m, input int h, input bit accept);
    entry_t e;
    e.data = d;
    e.mask = m;
    e.hold = 16'(h);
    push_valid_i = 1'b1;
    push_data_i  = e.data;
    push_mask_i  = e.mask;
    push_hold_i  = e.hold;
    tick();
    push_valid_i = 1'b0;
    if (accept) begin
      model_gpio = (model_gpio & ~e.mask) | (e.data & e.mask);
      repeat ((e.hold == 16'd0) ? 1 : int'(e.hold)) exp_q.push_back(model_gpio);
    end
  endtask

  task automatic run_cycles(input int n);
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
        break;
      end
      e = exp_q.pop_front();
      check("gpio", gpio_out_o, e);
      check("busy_run", 32'(busy_o), 32'd1);
      tick();
    end
  endtask

  task automatic play();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_cycles(exp_q.size());
    check("done_pulse", 32'(done_o), 32'd1);
    check("busy_end", 32'(busy_o), 32'd0);
    tick();
    check("done_clear", 32'(done_o), 32'd0);
  endtask

  initial begin
    prst = 1'b1; push_valid_i = 1'b0; push_data_i = '0; push_mask_i = '0; push_hold_i = '0;
    start_i = 1'b0; stop_i = 1'b0; flush_i = 1'b0; irq_clr_i = 1'b0;
    tick();
    tick();
    check("rst_gpio", gpio_out_o, 32'd0);
    check("rst_cnt", 32'(fifo_cnt_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_ready", 32'(push_ready_o), 32'd1);
    prst = 1'b0;
    tick();

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("start_empty_busy", 32'(busy_o), 32'd0);

    push(32'h1, 32'hF, 2, 1'b1);
    push(32'h2, 32'hF, 0, 1'b1);
    push(32'h4, 32'hF, 3, 1'b1);
    check("cnt3", 32'(fifo_cnt_o), 32'd3);
    play();
    check("gpio_retained", gpio_out_o, 32'h4);
    check("irq_after_done", 32'(irq_o), IRQ_EXP);

    push(32'hFF00, 32'hFFFF_FFFF, 1, 1'b1);
    push(32'h00FF, 32'h0F0F, 1, 1'b1);
    play();
    check("mask_merge", gpio_out_o, 32'hF00F);

    for (int i = 0; i < 8; i++) push(32'h100 + i, 32'hFFFF_FFFF, 1, 1'b1);
    check("cnt_full", 32'(fifo_cnt_o), 32'd8);
    check("ready_full", 32'(push_ready_o), 32'd0);
    push(32'hDEAD, 32'hFFFF_FFFF, 1, 1'b0);
    check("cnt_after_drop", 32'(fifo_cnt_o), 32'd8);
    play();

    for (int i = 1; i <= 4; i++) push(32'h10 * i, 32'hFFFF_FFFF, 5, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_cycles(2);
    stop_i = 1'b1;
    run_cycles(1);
    stop_i = 1'b0;
    check("stop_busy", 32'(busy_o), 32'd0);
    check("stop_done", 32'(done_o), 32'd0);
    check("stop_cnt", 32'(fifo_cnt_o), 32'd3);
    check("stop_gpio", gpio_out_o, 32'h10);
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    tick();
    check("stop_done_late", 32'(done_o), 32'd0);
    play();

    push(32'hA5A5, 32'hFFFF_FFFF, 4, 1'b1);
    push(32'h5A5A, 32'hFFFF_FFFF, 4, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_cycles(1);
    flush_i = 1'b1; stop_i = 1'b1; start_i = 1'b1;
    push_valid_i = 1'b1; push_data_i = 32'h1234; push_mask_i = 32'hFFFF_FFFF; push_hold_i = 16'd1;
    tick();
    flush_i = 1'b0; stop_i = 1'b0; start_i = 1'b0; push_valid_i = 1'b0;
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_cnt", 32'(fifo_cnt_o), 32'd0);
    check("flush_done", 32'(done_o), 32'd0);
    check("flush_gpio", gpio_out_o, 32'hA5A5);
    tick();
    check("flush_done_late", 32'(done_o), 32'd0);
    exp_q.delete();
    model_gpio = 32'hA5A5;

    push(32'h77, 32'hFFFF_FFFF, 1, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    push_valid_i = 1'b1; push_data_i = 32'h99; push_mask_i = 32'hFFFF_FFFF; push_hold_i = 16'd1;
    run_cycles(1);
    push_valid_i = 1'b0;
    check("late_push_busy", 32'(busy_o), 32'd0);
    check("late_push_done", 32'(done_o), 32'd1);
    check("late_push_cnt", 32'(fifo_cnt_o), 32'd1);
    check("late_push_gpio", gpio_out_o, 32'h77);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush2_cnt", 32'(fifo_cnt_o), 32'd0);

    irq_clr_i = 1'b1;
    tick();
    irq_clr_i = 1'b0;
    check("irq_cleared", 32'(irq_o), 32'd0);
    push(32'h3, 32'hFFFF_FFFF, 1, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    irq_clr_i = 1'b1;
    run_cycles(1);
    irq_clr_i = 1'b0;
    check("irq_set_wins_done", 32'(done_o), 32'd1);
    check("irq_set_wins", 32'(irq_o), IRQ_EXP);
    tick();
    check("irq_held", 32'(irq_o), IRQ_EXP);

    push(32'hBEEF, 32'hFFFF_FFFF, 3, 1'b1);
    push(32'hCAFE, 32'hFFFF_FFFF, 3, 1'b1);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    run_cycles(1);
    prst = 1'b1;
    tick();
    prst = 1'b0;
    check("rstrun_busy", 32'(busy_o), 32'd0);
    check("rstrun_cnt", 32'(fifo_cnt_o), 32'd0);
    check("rstrun_gpio", gpio_out_o, 32'd0);
    check("rstrun_irq", 32'(irq_o), 32'd0);
    exp_q.delete();
    model_gpio = '0;
    tick();
    check("rstrun_done", 32'(done_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
